exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameters DATA_W (default 8, data/literal width), ADDR_W (default 8, PC and data-address width), TIMEOUT (default 15, maximum cycles spent waiting for dmem_ack).
REQ-002 SHALL have the port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have the port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have the port run, input, 1 bit: level enable for starting or continuing execution.
REQ-005 SHALL have the port imem_data, input, 7+DATA_W bits: instruction at pc, {opcode[6:0], literal}, combinational ROM.
REQ-006 SHALL have the ports loadA_req, loadB_req, mem_read_req, mem_write_req and pc_load_req, inputs, 1 bit each: decoded strobes from the control unit for the current opcode.
REQ-007 SHALL have the port opcode, output, 7 bits: latched instruction opcode, fed to the control unit.
REQ-008 SHALL have the port literal, output, DATA_W bits: latched instruction literal.
REQ-009 SHALL have the port pc, output, ADDR_W bits: program counter, the instruction-memory address.
REQ-010 SHALL have the ports loadA, loadB and flags_en, outputs, 1 bit each: one-cycle gated write enables for register A, register B and the status flags.
REQ-011 SHALL have the ports dmem_req, output, 1 bit (data-memory request) and dmem_we, output, 1 bit (write qualifier, valid only while dmem_req=1).
REQ-012 SHALL have the port dmem_ack, input, 1 bit: data-memory completion, sampled on the same edge.
REQ-013 SHALL have the port busy, output, 1 bit: high in every state except IDLE and HALT.
REQ-014 SHALL have the port halted, output, 1 bit: high in the HALT state.
REQ-015 SHALL have the port err, output, 1 bit: sticky error flag.
REQ-016 SHALL have the port retired, output, 16 bits: retired-instruction count, wraps modulo 2^16.

Function
REQ-017 SHALL implement the states IDLE, FETCH, EXEC, MEM, WB and HALT.
REQ-018 IDLE: SHALL go to FETCH when run=1 and remain in IDLE otherwise.
REQ-019 FETCH: SHALL capture imem_data into {opcode, literal}, then go to EXEC.
REQ-020 EXEC with opcode 7'b1111111 (HALT): SHALL go to HALT with no write enables asserted and pc unchanged.
REQ-021 EXEC with both mem_read_req=1 and mem_write_req=1: SHALL set err=1 and go to HALT.
REQ-022 EXEC with either memory strobe set: SHALL go to MEM with dmem_req=1 and dmem_we=mem_write_req registered on entry to MEM.
REQ-023 EXEC with no memory strobe: for one cycle SHALL assert loadA=loadA_req, loadB=loadB_req and flags_en=1, update pc, and retire the instruction.
REQ-024 MEM: SHALL hold dmem_req and dmem_we stable until dmem_ack=1.
REQ-025 MEM, on ack with a read: SHALL go to WB.
REQ-026 MEM, on ack with a write: SHALL update pc, retire the instruction, and assert no loadA, loadB or flags_en.
REQ-027 MEM with no ack after TIMEOUT cycles in the state: SHALL deassert dmem_req, set err=1 and go to HALT.
REQ-028 WB: for one cycle SHALL assert loadA=loadA_req, loadB=loadB_req and flags_en=1, update pc, and retire the instruction.
REQ-029 pc update SHALL be pc_load_req ? literal[ADDR_W-1:0] : pc+1, with pc+1 wrapping from 2^ADDR_W-1 to 0.
REQ-030 After retiring an instruction, the next state SHALL be FETCH if run=1 and IDLE otherwise; run falling mid-instruction SHALL NOT abort that instruction.
REQ-031 HALT SHALL be exited only by reset.
REQ-032 Latency: a non-memory instruction SHALL take 2 cycles; a memory write SHALL take 3+w cycles and a memory read 4+w cycles, where w is the number of wait cycles before ack.
REQ-033 loadA, loadB and flags_en SHALL never be asserted outside EXEC and WB.
REQ-034 dmem_req SHALL never be asserted outside MEM.

Reset
REQ-035 rst_n=0 SHALL immediately force state=IDLE, pc=0, opcode=0, literal=0, retired=0, err=0 and every output strobe to 0, including dropping a dmem_req that is in flight.
REQ-036 The first FETCH after reset SHALL be from address 0.

Structure
REQ-037 The shared package arc_pkg SHALL hold the state enumeration, OP_HALT, DATA_W/ADDR_W defaults and the TIMEOUT default.
REQ-038 The timeout counter SHALL be a sub-module mem_wait_timer (inputs clear and enable; output expired), and the remainder SHALL be in exec_sequencer.

Verification
REQ-039 The bench SHALL cover reset then run=1, with ROM[0]=MOV A,lit 0x05: at FETCH+1 loadA=1 and flags_en=1 for one cycle, pc=1 and retired=1.
REQ-040 The bench SHALL cover JMP 0x10 at pc=3, pc_load_req=1: the next FETCH reads address 0x10, and no loadA, loadB or flags_en is asserted.
REQ-041 The bench SHALL cover MOV A,(Dir) with ack delayed 3 cycles: dmem_req is high for 4 cycles with dmem_we=0, then WB asserts loadA, and the instruction takes 7 cycles in total.
REQ-042 The bench SHALL cover MOV (Dir),B with ack never arriving: after 15 MEM cycles dmem_req=0, err=1 and halted=1.
REQ-043 The bench SHALL cover pc=0xFF executing a non-jump instruction: pc becomes 0x00; separately, rst_n=0 during MEM drops dmem_req asynchronously and returns the block to IDLE with pc=0.
REQ-044 The bench SHALL cover run dropped during EXEC: the instruction retires, the state goes to IDLE and busy=0; with run=1 again, fetch resumes at the next pc.

Source files
------------

// File: rtl/arc_pkg.sv
// arc_pkg: shared state encoding, halt opcode and default sizes for the instruction sequencer
package arc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [6:0] OP_HALT = 7'h7f;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on data memory, flags the last allowed one
module mem_wait_timer
  import arc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  // expired is high during the TIMEOUT-th waiting cycle, so the wait never exceeds TIMEOUT cycles
  assign expired = enable && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/execute/memory/writeback sequencer that drives register, flag and data-memory strobes
module exec_sequencer
  import arc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [6+DATA_W:0] imem_data,
  input  logic              loadA_req,
  input  logic              loadB_req,
  input  logic              mem_read_req,
  input  logic              mem_write_req,
  input  logic              pc_load_req,
  output logic [6:0]        opcode,
  output logic [DATA_W-1:0] literal,
  output logic [ADDR_W-1:0] pc,
  output logic              loadA,
  output logic              loadB,
  output logic              flags_en,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [15:0]       retired
);
  state_t state, nxt;
  logic mem_any, mem_bad, is_halt, expired, wen, retire;
  assign mem_any = mem_read_req | mem_write_req;
  assign mem_bad = mem_read_req & mem_write_req;
  assign is_halt = opcode == OP_HALT;
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != S_MEM),
    .enable (state == S_MEM),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = run ? S_FETCH : S_IDLE;
      S_FETCH: nxt = S_EXEC;
      S_EXEC:  nxt = (is_halt || mem_bad) ? S_HALT : mem_any ? S_MEM : run ? S_FETCH : S_IDLE;
      S_MEM:   nxt = dmem_ack ? (dmem_we ? (run ? S_FETCH : S_IDLE) : S_WB) : expired ? S_HALT : S_MEM;
      S_WB:    nxt = run ? S_FETCH : S_IDLE;
      default: nxt = S_HALT;
    endcase
  end
  // jumps commit only the pc, so they leave the flags untouched
  always_comb begin
    wen      = (state == S_EXEC && !is_halt && !mem_any) || state == S_WB;
    loadA    = wen & loadA_req;
    loadB    = wen & loadB_req;
    flags_en = wen & ~pc_load_req;
    dmem_req = state == S_MEM;
    retire   = wen || (dmem_req && dmem_ack && dmem_we);
    busy     = state != S_IDLE && state != S_HALT;
    halted   = state == S_HALT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opcode  <= '0;
      literal <= '0;
      pc      <= '0;
      retired <= '0;
      err     <= 1'b0;
      dmem_we <= 1'b0;
    end else begin
      if (state == S_FETCH) {opcode, literal} <= imem_data;
      if (retire) begin
        pc      <= pc_load_req ? ADDR_W'(literal) : pc + 1'b1;
        retired <= retired + 1'b1;
      end
      if (state == S_EXEC && nxt == S_MEM) dmem_we <= mem_write_req;
      if ((state == S_EXEC && !is_halt && mem_bad) || (dmem_req && !dmem_ack && expired)) err <= 1'b1;
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: instruction-level reference model compared against the sequencer every cycle
module tb_exec_sequencer;
  localparam int TO = 15;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, dmem_ack = 1'b0;
  logic [14:0] imem_data;
  logic loadA_req, loadB_req, mem_read_req, mem_write_req, pc_load_req;
  logic [6:0] opcode;
  logic [7:0] literal, pc;
  logic loadA, loadB, flags_en, dmem_req, dmem_we, busy, halted, err;
  logic [15:0] retired;
  logic [14:0] rom [256];
  always #5 clk = ~clk;
  assign imem_data = rom[pc];
  // control unit: opcode bit0 loadA, bit1 loadB, bit2 read, bit3 write, bit4 jump
  assign loadA_req = opcode[0];
  assign loadB_req = opcode[1];
  assign mem_read_req = opcode[2];
  assign mem_write_req = opcode[3];
  assign pc_load_req = opcode[4];
  exec_sequencer #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_data(imem_data),
    .loadA_req(loadA_req), .loadB_req(loadB_req), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .pc_load_req(pc_load_req),
    .opcode(opcode), .literal(literal), .pc(pc), .loadA(loadA), .loadB(loadB),
    .flags_en(flags_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .busy(busy), .halted(halted), .err(err), .retired(retired)
  );
  typedef struct packed {
    logic b, h, la, lb, fe, rq, we, er;
    logic [7:0] pc;
    logic [15:0] ret;
  } exp_t;
  exp_t exp_v, act_v;
  logic chk_en = 1'b0;
  int n_chk = 0, n_err = 0, obs_req = 0, obs_busy = 0;
  logic [7:0] m_pc = '0;
  logic [15:0] m_ret = '0;
  logic m_err = 1'b0, m_halt = 1'b0;
  always @(negedge clk) if (chk_en) begin
    act_v = {busy, halted, loadA, loadB, flags_en, dmem_req, dmem_req & dmem_we, err, pc, retired};
    n_chk++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL cycle t=%0t b/h/la/lb/fe/rq/we/err got %b pc=%h ret=%0d want %b pc=%h ret=%0d",
               $time, act_v[31:24], act_v.pc, act_v.ret, exp_v[31:24], exp_v.pc, exp_v.ret);
    end
    obs_req += int'(dmem_req);
    obs_busy += int'(busy);
  end
  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask
  function automatic exp_t mk(input logic b, h, la, lb, fe, rq, we);
    return {b, h, la, lb, fe, rq, rq & we, m_err, m_pc, m_ret};
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic cyc(input logic r, input logic a, input exp_t e);
    run = r;
    dmem_ack = a;
    exp_v = e;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
  endtask
  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(rb(), 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
  endtask
  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    run = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_pc = '0;
    m_ret = '0;
    m_err = 1'b0;
    m_halt = 1'b0;
  endtask
  // one instruction from its FETCH cycle; w = wait cycles before ack, rret = run on the retiring cycle
  task automatic instr(input int w, input logic rret);
    logic [6:0] op;
    logic [7:0] lt;
    logic la, lb, rd, wr, pl;
    {op, lt} = rom[m_pc];
    {pl, wr, rd, lb, la} = op[4:0];
    cyc(rb(), 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    if (op == 7'h7f || (rd && wr)) begin
      cyc(rb(), 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
      if (op != 7'h7f) m_err = 1'b1;
      m_halt = 1'b1;
      return;
    end
    if (!rd && !wr) begin
      cyc(rret, 1'b0, mk(1, 0, la, lb, !pl, 0, 0));
    end else begin
      cyc(rb(), 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < TO && k <= w; k++)
        cyc((k == w && wr) ? rret : rb(), k == w, mk(1, 0, 0, 0, 0, 1, wr));
      if (w >= TO) begin
        m_err = 1'b1;
        m_halt = 1'b1;
        return;
      end
      if (rd) cyc(rret, 1'b0, mk(1, 0, la, lb, !pl, 0, 0));
    end
    m_pc = pl ? lt : m_pc + 8'd1;
    m_ret++;
  endtask
  function automatic logic [14:0] rand_instr();
    int k;
    logic [6:0] op;
    k = $urandom_range(0, 99);
    op = {5'b0, 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 7) == 0) op[4] = 1'b1;
    if (k < 2) op = 7'h7f;
    else if (k < 4) op[3:2] = 2'b11;
    else if (k < 20) op[2] = 1'b1;
    else if (k < 35) op[3] = 1'b1;
    return {op, 8'($urandom)};
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int b0, b1, w, k;
    logic rr;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = {7'h01, 8'h05};
    rom[3] = {7'h10, 8'h10};
    rom[16] = {7'h05, 8'h20};
    rom[17] = {7'h08, 8'h30};
    do_reset();
    lit("reset_pc", pc, 0);
    lit("reset_state", {busy, halted, err, dmem_req, loadA, loadB, flags_en}, 0);
    lit("reset_retired", retired, 0);
    idle(0);
    instr(0, 1'b1);
    lit("mov_a_pc", pc, 1);
    lit("mov_a_retired", retired, 1);
    lit("mov_a_one_cycle", {loadA, flags_en}, 0);
    instr(0, 1'b1);
    instr(0, 1'b1);
    instr(0, 1'b1);
    lit("jmp_pc", pc, 8'h10);
    b0 = obs_req;
    b1 = obs_busy;
    instr(3, 1'b1);
    lit("read_req_cycles", obs_req - b0, 4);
    lit("read_total_cycles", obs_busy - b1, 7);
    b0 = obs_req;
    instr(100, 1'b1);
    lit("timeout_req_cycles", obs_req - b0, 15);
    lit("timeout_req_err_halt", {dmem_req, err, halted}, 3'b011);
    halt_cycles(3);
    rom[0] = {7'h10, 8'hff};
    rom[255] = {7'h02, 8'h11};
    do_reset();
    idle(1);
    instr(0, 1'b1);
    instr(0, 1'b1);
    lit("pc_wrap", pc, 0);
    rom[0] = '0;
    rom[1] = {7'h04, 8'h40};
    do_reset();
    idle(0);
    instr(0, 1'b1);
    cyc(1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 1'b0, mk(1, 0, 0, 0, 0, 1, 0));
    cyc(1'b1, 1'b0, mk(1, 0, 0, 0, 0, 1, 0));
    chk_en = 1'b0;
    lit("mem_req_before_reset", dmem_req, 1);
    rst_n = 1'b0;
    #1;
    lit("async_reset_req", dmem_req, 0);
    lit("async_reset_idle", {busy, halted}, 0);
    lit("async_reset_pc", pc, 0);
    rom[0] = {7'h01, 8'h33};
    rom[1] = {7'h02, 8'h44};
    do_reset();
    idle(0);
    instr(0, 1'b0);
    lit("run_drop_busy", busy, 0);
    lit("run_drop_pc", pc, 1);
    idle(2);
    instr(0, 1'b1);
    lit("resume_pc", pc, 2);
    for (int i = 0; i < 256; i++) rom[i] = rand_instr();
    do_reset();
    idle(0);
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 19);
      w = (k == 0) ? 20 : (k == 1) ? TO - 1 : $urandom_range(0, 4);
      rr = $urandom_range(0, 3) != 0;
      instr(w, rr);
      if (m_halt) begin
        halt_cycles(2);
        do_reset();
        idle($urandom_range(0, 2));
      end else if (!rr) begin
        idle($urandom_range(0, 2));
      end
    end
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
